// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC and the IF/ID pipeline register. It also counts
// the instructions loaded into IF/ID and the flushes it has accepted.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic [13:0] irom_adr,
    input  logic [31:0] irom_inst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_cnt,
    output logic [15:0] flush_cnt
);

    logic [31:0] r_pc_q, r_pc_d;
    logic [31:0] r_inst_q, r_inst_d;
    logic [31:0] r_id_pc_q, r_id_pc_d;
    logic [31:0] r_id_pc4_q, r_id_pc4_d;
    logic        r_valid_q, r_valid_d;
    logic [31:0] r_fcnt_q, r_fcnt_d;
    logic [15:0] r_flcnt_q, r_flcnt_d;
    logic [31:0] w_pc_plus4;
    logic        w_unused;

    assign w_pc_plus4 = r_pc_q + 32'd4;
    // Byte-offset bits of the redirect target are dropped without raising an exception.
    assign w_unused   = ^redirect_pc[1:0];

    always_comb begin
        r_pc_d     = r_pc_q;
        r_inst_d   = r_inst_q;
        r_id_pc_d  = r_id_pc_q;
        r_id_pc4_d = r_id_pc4_q;
        r_valid_d  = r_valid_q;
        r_fcnt_d   = r_fcnt_q;
        r_flcnt_d  = r_flcnt_q;
        if (flush) begin
            // A flush overrides a simultaneous stall.
            r_pc_d     = {redirect_pc[31:2], 2'b00};
            r_inst_d   = NOP_INST;
            r_id_pc_d  = 32'd0;
            r_id_pc4_d = 32'd0;
            r_valid_d  = 1'b0;
            if (r_flcnt_q != 16'hFFFF) begin
                r_flcnt_d = r_flcnt_q + 16'd1;
            end
        end else if (!stall) begin
            r_pc_d     = w_pc_plus4;
            r_inst_d   = irom_inst;
            r_id_pc_d  = r_pc_q;
            r_id_pc4_d = w_pc_plus4;
            r_valid_d  = 1'b1;
            r_fcnt_d   = r_fcnt_q + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_pc_q     <= RESET_PC;
            r_inst_q   <= NOP_INST;
            r_id_pc_q  <= 32'd0;
            r_id_pc4_q <= 32'd0;
            r_valid_q  <= 1'b0;
            r_fcnt_q   <= 32'd0;
            r_flcnt_q  <= 16'd0;
        end else begin
            r_pc_q     <= r_pc_d;
            r_inst_q   <= r_inst_d;
            r_id_pc_q  <= r_id_pc_d;
            r_id_pc4_q <= r_id_pc4_d;
            r_valid_q  <= r_valid_d;
            r_fcnt_q   <= r_fcnt_d;
            r_flcnt_q  <= r_flcnt_d;
        end
    end

    assign irom_adr  = r_pc_q[15:2];
    assign pc        = r_pc_q;
    assign id_inst   = r_inst_q;
    assign id_pc     = r_id_pc_q;
    assign id_pc4    = r_id_pc4_q;
    assign id_valid  = r_valid_q;
    assign fetch_cnt = r_fcnt_q;
    assign flush_cnt = r_flcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/flush/reset traffic,
// all checked against a transaction-level model of the IF stage.
module tb_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0000;
    localparam logic [31:0] Nop   = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic [13:0] irom_adr;
    logic [31:0] irom_inst;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc, id_inst, id_pc, id_pc4, fetch_cnt;
    logic        id_valid;
    logic [15:0] flush_cnt;

    logic [31:0] rom [0:16383];

    // Reference state.
    logic [31:0] m_pc, m_inst, m_id_pc, m_id_pc4, m_fcnt;
    logic        m_valid;
    logic [15:0] m_flcnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_PC (RstPc),
        .NOP_INST (Nop)
    ) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .irom_adr    (irom_adr),
        .irom_inst   (irom_inst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign irom_inst = rom[irom_adr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},        pc,                       m_pc);
        check({tag, ".irom_adr"},  {18'd0, irom_adr},        {18'd0, m_pc[15:2]});
        check({tag, ".id_inst"},   id_inst,                  m_inst);
        check({tag, ".id_pc"},     id_pc,                    m_id_pc);
        check({tag, ".id_pc4"},    id_pc4,                   m_id_pc4);
        check({tag, ".id_valid"},  {31'd0, id_valid},        {31'd0, m_valid});
        check({tag, ".fetch_cnt"}, fetch_cnt,                m_fcnt);
        check({tag, ".flush_cnt"}, {16'd0, flush_cnt},       {16'd0, m_flcnt});
    endtask

    // One clock edge with the given controls; model follows the priority rst > flush > stall.
    task automatic step(input logic rst, input logic fl, input logic st,
                        input logic [31:0] rp, input bit do_check, input string tag);
        cpu_rst     = rst;
        flush       = fl;
        stall       = st;
        redirect_pc = rp;
        @(posedge cpu_clk);
        if (rst) begin
            m_pc = RstPc; m_inst = Nop; m_id_pc = 0; m_id_pc4 = 0;
            m_valid = 0; m_fcnt = 0; m_flcnt = 0;
        end else if (fl) begin
            m_pc = rp & 32'hFFFF_FFFC;
            m_inst = Nop; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0;
            if (m_flcnt != 16'hFFFF) m_flcnt = m_flcnt + 1;
        end else if (!st) begin
            m_inst   = rom[m_pc[15:2]];
            m_id_pc  = m_pc;
            m_id_pc4 = m_pc + 4;
            m_pc     = m_pc + 4;
            m_valid  = 1;
            m_fcnt   = m_fcnt + 1;
        end
        #1;
        if (do_check) check_all(tag);
    endtask

    initial begin
        logic [31:0] saved_fcnt;
        for (int i = 0; i < 16384; i++) rom[i] = $urandom;

        step(1, 0, 0, 0, 1, "reset");
        check("reset.id_inst_nop", id_inst, Nop);
        check("reset.pc", pc, RstPc);

        // Free-running fetch, then a two-edge stall while B is in IF/ID.
        step(0, 0, 0, 0, 1, "adv0");
        check("adv0.inst_A", id_inst, rom[0]);
        check("adv0.id_pc", id_pc, 32'd0);
        check("adv0.valid", {31'd0, id_valid}, 32'd1);
        step(0, 0, 0, 0, 1, "adv1");
        check("adv1.inst_B", id_inst, rom[1]);
        check("adv1.id_pc", id_pc, 32'd4);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0, 1, "stall");
            check("stall.inst_B", id_inst, rom[1]);
            check("stall.pc", pc, 32'd8);
            check("stall.fcnt", fetch_cnt, 32'd2);
        end
        step(0, 0, 0, 0, 1, "adv2");
        check("adv2.inst_C", id_inst, rom[2]);
        check("adv2.id_pc", id_pc, 32'd8);
        check("adv2.pc", pc, 32'd12);
        check("adv2.fcnt", fetch_cnt, 32'd3);

        // Flush beats stall; low redirect bits are dropped.
        step(0, 1, 1, 32'h0000_0103, 1, "flst");
        check("flst.pc", pc, 32'h100);
        check("flst.inst", id_inst, Nop);
        check("flst.valid", {31'd0, id_valid}, 32'd0);
        check("flst.flcnt", {16'd0, flush_cnt}, 32'd1);
        step(0, 0, 0, 0, 1, "postfl");
        check("postfl.id_pc", id_pc, 32'h100);

        // PC wrap at the top of the address space.
        step(0, 1, 0, 32'hFFFF_FFFC, 1, "wrapfl");
        step(0, 0, 0, 0, 1, "wrap");
        check("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap.id_pc4", id_pc4, 32'd0);
        check("wrap.pc", pc, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(3) == 0), $urandom, 1, "rand");
        end

        // Long flush run drives flush_cnt into saturation.
        saved_fcnt = m_fcnt;
        for (int i = 0; i < 65540; i++) step(0, 1, $urandom_range(1), $urandom, 0, "");
        check_all("sat");
        check("sat.flcnt", {16'd0, flush_cnt}, 32'h0000_FFFF);
        check("sat.fcnt", fetch_cnt, saved_fcnt);
        step(0, 1, 0, 32'h40, 1, "sat2");
        check("sat2.flcnt", {16'd0, flush_cnt}, 32'h0000_FFFF);

        // Reset wins over simultaneous flush and stall mid-run.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, "prerst");
        step(1, 1, 1, 32'h1234_5678, 1, "rstmid");
        check("rstmid.pc", pc, RstPc);
        check("rstmid.inst", id_inst, Nop);
        check("rstmid.id_pc4", id_pc4, 32'd0);
        check("rstmid.valid", {31'd0, id_valid}, 32'd0);
        check("rstmid.fcnt", fetch_cnt, 32'd0);
        check("rstmid.flcnt", {16'd0, flush_cnt}, 32'd0);
        step(0, 0, 0, 0, 1, "afterrst");
        check("afterrst.inst", id_inst, rom[RstPc[15:2]]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
